// File: rtl/bcm_painter_if.sv
// Scan-stream interface between the LED scan generator and bcm_painter.
// Carries the pixel request (master drives) and the registered rgb result (slave drives).
interface bcm_painter_if #(
  parameter int unsigned W_X     = 6,
  parameter int unsigned W_Y     = 6,
  parameter int unsigned W_FRAME = 13,
  parameter int unsigned W_SUB   = 8
);
  logic               in_valid;
  logic [W_FRAME-1:0] frame;
  logic [W_SUB-1:0]   subframe;
  logic [W_X-1:0]     x;
  logic [W_Y-1:0]     y;
  logic [1:0]         mode;
  logic               out_valid;
  logic [2:0]         rgb;

  modport master (
    output in_valid, frame, subframe, x, y, mode,
    input  out_valid, rgb
  );

  modport slave (
    input  in_valid, frame, subframe, x, y, mode,
    output out_valid, rgb
  );
endinterface

// File: rtl/bcm_painter.sv
// Test-pattern painter: per-pixel R/G/B intensity from a frame-latched pattern mode,
// compared against the BCM subframe. Optional gamma stage under BCM_PAINTER_GAMMA_EN.
module bcm_painter #(
  parameter int unsigned W_X        = 6,
  parameter int unsigned W_Y        = 6,
  parameter int unsigned W_FRAME    = 13,
  parameter int unsigned W_SUB      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CHK_BIT    = 3,
  parameter int unsigned PHASE_BIT  = 5,
  parameter logic [1:0]  MODE_RESET = 2'd0
) (
  input  logic          clk,
  input  logic          reset,
  bcm_painter_if.slave  bus
);

  localparam int unsigned S      = DEPTH - W_X;
  localparam int unsigned T      = DEPTH - W_Y;
  localparam int unsigned W_PROD = 2 * DEPTH;
  localparam logic [DEPTH-1:0] FULL = '1;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SCROLL   = 2'd3
  } mode_e;

  // Frame-latched mode shadow
  logic [1:0]         mode_q, mode_d;
  logic [W_FRAME-1:0] frame_prev_q, frame_prev_d;

  // S1: intensities
  logic               s1_valid_q, s1_valid_d;
  logic               s1_solid_q, s1_solid_d;
  logic [DEPTH-1:0]   s1_r_q, s1_r_d;
  logic [DEPTH-1:0]   s1_g_q, s1_g_d;
  logic [DEPTH-1:0]   s1_b_q, s1_b_d;
  logic [DEPTH-1:0]   s1_sub_q, s1_sub_d;

`ifdef BCM_PAINTER_GAMMA_EN
  // Gamma stage
  logic               gm_valid_q, gm_valid_d;
  logic               gm_solid_q, gm_solid_d;
  logic [DEPTH-1:0]   gm_r_q, gm_r_d;
  logic [DEPTH-1:0]   gm_g_q, gm_g_d;
  logic [DEPTH-1:0]   gm_b_q, gm_b_d;
  logic [DEPTH-1:0]   gm_sub_q, gm_sub_d;

  function automatic logic [DEPTH-1:0] gamma_sq(input logic [DEPTH-1:0] i);
    logic [W_PROD-1:0] p;
    p = W_PROD'(i) * W_PROD'(i);
    return p[W_PROD-1:DEPTH];
  endfunction
`endif

  // S2: compare result
  logic               out_valid_q, out_valid_d;
  logic [2:0]         rgb_q, rgb_d;

  // Compare-stage sources (S1 or gamma stage)
  logic               cmp_valid, cmp_solid;
  logic [DEPTH-1:0]   cmp_r, cmp_g, cmp_b, cmp_sub;

  logic               new_frame;
  mode_e              mode_eff;
  logic               chk_on;
  logic [W_X-1:0]     scroll_v;
  logic [DEPTH-1:0]   x_scaled;

  always_comb begin
    mode_d       = mode_q;
    frame_prev_d = frame_prev_q;
    s1_r_d       = '0;
    s1_g_d       = '0;
    s1_b_d       = '0;
    chk_on       = 1'b0;
    scroll_v     = '0;

    // A new frame number latches the requested mode and applies it to this pixel
    new_frame = bus.in_valid && (bus.frame != frame_prev_q);
    if (new_frame) begin
      mode_d       = bus.mode;
      frame_prev_d = bus.frame;
    end
    mode_eff = mode_e'(new_frame ? bus.mode : mode_q);
    x_scaled = DEPTH'(bus.x) << S;

    unique case (mode_eff)
      MODE_SOLID: begin
        s1_r_d = '0;
      end
      MODE_GRADIENT: begin
        s1_r_d = x_scaled;
        s1_g_d = DEPTH'(bus.y) << T;
        s1_b_d = FULL - x_scaled;
      end
      MODE_CHECKER: begin
        chk_on = bus.x[CHK_BIT] ^ bus.y[CHK_BIT] ^ bus.frame[PHASE_BIT];
        s1_r_d = chk_on ? FULL : '0;
        s1_g_d = chk_on ? FULL : '0;
        s1_b_d = chk_on ? FULL : '0;
      end
      MODE_SCROLL: begin
        scroll_v = bus.x + bus.frame[W_X-1:0];
        s1_r_d   = DEPTH'(scroll_v) << S;
        s1_g_d   = DEPTH'(scroll_v) << S;
        s1_b_d   = DEPTH'(scroll_v) << S;
      end
      default: s1_r_d = '0;
    endcase

    s1_valid_d = bus.in_valid;
    s1_solid_d = (mode_eff == MODE_SOLID);
    s1_sub_d   = bus.subframe[DEPTH-1:0];

`ifdef BCM_PAINTER_GAMMA_EN
    gm_valid_d = s1_valid_q;
    gm_solid_d = s1_solid_q;
    gm_r_d     = gamma_sq(s1_r_q);
    gm_g_d     = gamma_sq(s1_g_q);
    gm_b_d     = gamma_sq(s1_b_q);
    gm_sub_d   = s1_sub_q;

    cmp_valid  = gm_valid_q;
    cmp_solid  = gm_solid_q;
    cmp_r      = gm_r_q;
    cmp_g      = gm_g_q;
    cmp_b      = gm_b_q;
    cmp_sub    = gm_sub_q;
`else
    cmp_valid  = s1_valid_q;
    cmp_solid  = s1_solid_q;
    cmp_r      = s1_r_q;
    cmp_g      = s1_g_q;
    cmp_b      = s1_b_q;
    cmp_sub    = s1_sub_q;
`endif

    // Solid mode bypasses the compare so legacy white stays fully on
    out_valid_d = cmp_valid;
    rgb_d       = cmp_solid ? 3'b111
                            : {cmp_b > cmp_sub, cmp_g > cmp_sub, cmp_r > cmp_sub};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_RESET;
      frame_prev_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_solid_q   <= 1'b0;
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      s1_sub_q     <= '0;
`ifdef BCM_PAINTER_GAMMA_EN
      gm_valid_q   <= 1'b0;
      gm_solid_q   <= 1'b0;
      gm_r_q       <= '0;
      gm_g_q       <= '0;
      gm_b_q       <= '0;
      gm_sub_q     <= '0;
`endif
      out_valid_q  <= 1'b0;
      rgb_q        <= 3'b000;
    end else begin
      mode_q       <= mode_d;
      frame_prev_q <= frame_prev_d;
      s1_valid_q   <= s1_valid_d;
      s1_solid_q   <= s1_solid_d;
      s1_r_q       <= s1_r_d;
      s1_g_q       <= s1_g_d;
      s1_b_q       <= s1_b_d;
      s1_sub_q     <= s1_sub_d;
`ifdef BCM_PAINTER_GAMMA_EN
      gm_valid_q   <= gm_valid_d;
      gm_solid_q   <= gm_solid_d;
      gm_r_q       <= gm_r_d;
      gm_g_q       <= gm_g_d;
      gm_b_q       <= gm_b_d;
      gm_sub_q     <= gm_sub_d;
`endif
      out_valid_q  <= out_valid_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.rgb       = rgb_q;

endmodule
